// File: rtl/lpf_pkg.sv
// Shared types and constants for the line prefetch controller.
package lpf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD,
        DRAIN
    } lpf_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/line_prefetch_ctrl.sv
// Double-buffered video line prefetch from DDR into an external dual-port line buffer.
// Define LPF_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module line_prefetch_ctrl
    import lpf_pkg::*;
#(
    parameter int LINE_WORDS = 256,
    parameter int LINES      = 224,
    parameter int ADDR_W     = 28
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        frame_start,
    input  logic                        line_done,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ready,
    output logic                        buf_we,
    output logic [$clog2(LINE_WORDS):0] buf_waddr,
    output logic                        rd_bank,
    output logic                        busy,
    output logic                        underrun
`ifdef LPF_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                 underrun_cnt
`endif
);

    localparam int WW = $clog2(LINE_WORDS);
    localparam int LW = $clog2(LINES + 1);
    localparam logic [WW-1:0]     WORD_LAST = WW'(LINE_WORDS - 1);
    localparam logic [LW-1:0]     LINE_END  = LW'(LINES);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

    lpf_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [WW-1:0]     word_reg, word_next;
    logic [LW-1:0]     line_reg, line_next;
    logic              fill_bank_reg, fill_bank_next;
    logic              rd_bank_reg, rd_bank_next;
    logic              pend_reg, pend_next;
    logic              req_reg, req_next;
    logic              restart_reg, restart_next;
    logic              underrun_reg, underrun_next;
    logic              restart_now;
    logic              abort;
    logic              wr_en;
    logic [LW-1:0]     line_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            base_reg      <= '0;
            word_reg      <= '0;
            line_reg      <= '0;
            fill_bank_reg <= 1'b0;
            rd_bank_reg   <= 1'b0;
            pend_reg      <= 1'b0;
            req_reg       <= 1'b0;
            restart_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            base_reg      <= base_next;
            word_reg      <= word_next;
            line_reg      <= line_next;
            fill_bank_reg <= fill_bank_next;
            rd_bank_reg   <= rd_bank_next;
            pend_reg      <= pend_next;
            req_reg       <= req_next;
            restart_reg   <= restart_next;
            underrun_reg  <= underrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        base_next      = frame_start ? base_addr : base_reg;
        word_next      = word_reg;
        line_next      = line_reg;
        fill_bank_next = fill_bank_reg;
        rd_bank_next   = rd_bank_reg;
        pend_next      = pend_reg;
        req_next       = req_reg;
        restart_next   = restart_reg;
        underrun_next  = 1'b0;
        restart_now    = 1'b0;
        abort          = frame_start || !enable;
        wr_en          = (state_reg == FILL) && req_reg && mem_ready && !abort;
        line_inc       = line_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                if (frame_start && enable)
                    restart_now = 1'b1;
            end
            FILL: begin
                if (abort) begin
                    // A request the DDR has not answered yet must still be absorbed.
                    if (req_reg && !mem_ready) begin
                        state_next   = DRAIN;
                        restart_next = frame_start && enable;
                    end else if (frame_start && enable) begin
                        restart_now = 1'b1;
                    end else begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end else begin
                    if (line_done)
                        pend_next = 1'b1;
                    if (!req_reg) begin
                        req_next = 1'b1;
                    end else if (mem_ready) begin
                        req_next  = 1'b0;
                        addr_next = addr_reg + ADDR_STEP;
                        word_next = word_reg + 1'b1;
                        if (word_reg == WORD_LAST) begin
                            line_next = line_inc;
                            if (line_reg == '0) begin
                                fill_bank_next = 1'b1;
                            end else if (pend_reg || line_done) begin
                                // Display already wanted this line: switch late and flag it.
                                rd_bank_next  = ~rd_bank_reg;
                                underrun_next = 1'b1;
                                pend_next     = 1'b0;
                                if (line_inc == LINE_END)
                                    state_next = IDLE;
                                else
                                    fill_bank_next = rd_bank_reg;
                            end else begin
                                state_next = HOLD;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_start && enable) begin
                    restart_now = 1'b1;
                end else if (!enable) begin
                    state_next = IDLE;
                end else if (line_done) begin
                    // The last fetched line still gets its bank switch before going idle.
                    rd_bank_next = ~rd_bank_reg;
                    if (line_reg == LINE_END) begin
                        state_next = IDLE;
                    end else begin
                        fill_bank_next = rd_bank_reg;
                        state_next     = FILL;
                        req_next       = 1'b1;
                    end
                end
            end
            DRAIN: begin
                restart_next = (restart_reg || frame_start) && enable;
                if (mem_ready) begin
                    req_next = 1'b0;
                    if ((restart_reg || frame_start) && enable)
                        restart_now = 1'b1;
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (restart_now) begin
            state_next     = FILL;
            addr_next      = base_next;
            word_next      = '0;
            line_next      = '0;
            fill_bank_next = 1'b0;
            rd_bank_next   = 1'b0;
            pend_next      = 1'b0;
            req_next       = 1'b1;
            restart_next   = 1'b0;
        end
    end

    // The DDR channel shares this reset, so the request is withdrawn within the reset cycle.
    assign mem_req   = req_reg && !reset;
    assign buf_we    = wr_en && !reset;
    assign mem_addr  = addr_reg;
    assign buf_waddr = {fill_bank_reg, word_reg};
    assign rd_bank   = rd_bank_reg;
    assign busy      = (state_reg != IDLE);
    assign underrun  = underrun_reg;

`ifdef LPF_UNDERRUN_CNT_EN
    logic [15:0] ucnt_reg;

    always_ff @(posedge clk) begin
        if (reset)
            ucnt_reg <= '0;
        else if (underrun_next && (ucnt_reg != 16'hFFFF))
            ucnt_reg <= ucnt_reg + 16'd1;
    end

    assign underrun_cnt = ucnt_reg;
`endif

endmodule

// File: tb/tb_line_prefetch_ctrl.sv
// Directed bench for line_prefetch_ctrl with a latency-programmable DDR responder.
module tb_line_prefetch_ctrl;

    localparam int LWD = 16;
    localparam int NLN = 4;
    localparam int AW  = 28;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          frame_start = 1'b0;
    logic          line_done = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          buf_we;
    logic [4:0]    buf_waddr;
    logic          rd_bank;
    logic          busy;
    logic          underrun;
`ifdef LPF_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int lat = 3;
    int rcnt = 0;
    int und_n = 0;
    int m = 0;
    logic [AW-1:0] wa_q[$];
    logic [4:0]    wb_q[$];

    always #5 clk = ~clk;

    line_prefetch_ctrl #(.LINE_WORDS(LWD), .LINES(NLN), .ADDR_W(AW)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .base_addr(base_addr),
        .frame_start(frame_start),
        .line_done(line_done),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .buf_we(buf_we),
        .buf_waddr(buf_waddr),
        .rd_bank(rd_bank),
        .busy(busy),
        .underrun(underrun)
`ifdef LPF_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    // DDR model: answers a held request after `lat` further cycles.
    always @(negedge clk) begin
        if (reset) begin
            mem_ready = 1'b0;
            rcnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (rcnt >= lat) begin
                mem_ready = 1'b1;
                rcnt = 0;
            end else begin
                rcnt++;
            end
        end else begin
            rcnt = 0;
        end
    end

    always @(negedge clk) begin
        #3;
        if (buf_we) begin
            wa_q.push_back(mem_addr);
            wb_q.push_back(buf_waddr);
            $display("WRITE t=%0t addr=%h waddr=%h", $time, mem_addr, buf_waddr);
        end
        if (underrun) und_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_frame(input logic [AW-1:0] b);
        base_addr = b;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_ld();
        line_done = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && wa_q.size() < n; i++) @(negedge clk);
        chk(tag, 32'(wa_q.size() >= n), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 200 && !mem_req; i++) @(negedge clk);
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic chk_line(input int s, input logic [AW-1:0] a0, input logic bank, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < LWD; i++) begin
            if (s + i >= wa_q.size()) bad++;
            else if (wa_q[s+i] !== a0 + AW'(4 * i) || wb_q[s+i] !== {bank, 4'(i)}) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({pfx, "_buf_we"}, 32'(buf_we), 32'd0);
        chk({pfx, "_buf_waddr"}, 32'(buf_waddr), 32'd0);
        chk({pfx, "_rd_bank"}, 32'(rd_bank), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_underrun"}, 32'(underrun), 32'd0);
`ifdef LPF_UNDERRUN_CNT_EN
        chk({pfx, "_ucnt"}, 32'(underrun_cnt), 32'd0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Frame 1: lines 0 and 1 prefetched, then HOLD.
        enable = 1'b1;
        lat = 3;
        pulse_frame(28'h0001000);
        wait_writes(32, 600, "f1_prefetch_done");
        repeat (8) @(negedge clk);
        chk("f1_write_count", 32'(wa_q.size()), 32'd32);
        chk("f1_hold_req", 32'(mem_req), 32'd0);
        chk("f1_hold_busy", 32'(busy), 32'd1);
        chk("f1_rd_bank0", 32'(rd_bank), 32'd0);
        chk_line(0, 28'h0001000, 1'b0, "f1_line0");
        chk_line(16, 28'h0001040, 1'b1, "f1_line1");

        pulse_ld();
        chk("ld1_rd_bank", 32'(rd_bank), 32'd1);
        wait_writes(48, 400, "f1_line2_done");
        chk_line(32, 28'h0001080, 1'b0, "f1_line2");
        repeat (5) @(negedge clk);
        chk("f1_hold2_req", 32'(mem_req), 32'd0);
        pulse_ld();
        chk("ld2_rd_bank", 32'(rd_bank), 32'd0);
        wait_writes(64, 400, "f1_line3_done");
        chk_line(48, 28'h00010C0, 1'b1, "f1_line3");
        repeat (5) @(negedge clk);
        pulse_ld();
        chk("ld3_rd_bank", 32'(rd_bank), 32'd1);
        chk("ld3_idle", 32'(busy), 32'd0);
        pulse_ld();
        chk("ld4_ignored_rd", 32'(rd_bank), 32'd1);
        chk("ld4_ignored_busy", 32'(busy), 32'd0);
        chk("f1_total_writes", 32'(wa_q.size()), 32'd64);

        // Frame 2: slow DDR, line_done arrives while line 2 is still filling.
        pulse_frame(28'h0002000);
        wait_writes(96, 600, "f2_prefetch_done");
        repeat (3) @(negedge clk);
        lat = 40;
        pulse_ld();
        chk("f2_ld_rd_bank", 32'(rd_bank), 32'd1);
        repeat (60) @(negedge clk);
        pulse_ld();
        repeat (5) @(negedge clk);
        chk("f2_no_early_toggle", 32'(rd_bank), 32'd1);
        chk("f2_no_early_underrun", 32'(und_n), 32'd0);
        wait_writes(112, 1500, "f2_line2_done");
        chk("f2_late_toggle", 32'(rd_bank), 32'd0);
        chk("f2_underrun_pulse", 32'(underrun), 32'd1);
        lat = 0;
        wait_writes(128, 400, "f2_line3_done");
        repeat (5) @(negedge clk);
        chk("f2_hold_req", 32'(mem_req), 32'd0);
        chk("f2_hold_busy", 32'(busy), 32'd1);
        pulse_ld();
        chk("f2_final_rd", 32'(rd_bank), 32'd1);
        chk("f2_idle", 32'(busy), 32'd0);
        chk("f2_underrun_total", 32'(und_n), 32'd1);
`ifdef LPF_UNDERRUN_CNT_EN
        chk("f2_underrun_cnt", 32'(underrun_cnt), 32'd1);
`endif
        chk_line(96, 28'h0002080, 1'b0, "f2_line2");
        chk_line(112, 28'h00020C0, 1'b1, "f2_line3");

        // frame_start with a request in flight: that word is dropped.
        lat = 10;
        pulse_frame(28'h0003000);
        wait_writes(130, 200, "f3_two_words");
        wait_req("f3_req_up");
        repeat (2) @(negedge clk);
        chk("f3_pending_addr", 32'(mem_addr), 32'h0003008);
        m = wa_q.size();
        pulse_frame(28'h0004000);
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_req_held", 32'(mem_req), 32'd1);
        chk("drain_addr_held", 32'(mem_addr), 32'h0003008);
        wait_writes(m + 1, 200, "f4_first_write");
        chk("f4_first_addr", 32'(wa_q[m]), 32'h0004000);
        chk("f4_first_waddr", 32'(wb_q[m]), 32'd0);

        // Address wrap at the top of the DDR space.
        lat = 3;
        m = wa_q.size();
        pulse_frame(28'hFFFFFF8);
        wait_writes(m + 3, 100, "wrap_writes");
        chk("wrap_addr0", 32'(wa_q[m]), 32'h0FFFFFF8);
        chk("wrap_addr1", 32'(wa_q[m+1]), 32'h0FFFFFFC);
        chk("wrap_addr2", 32'(wa_q[m+2]), 32'h00000000);
        chk("wrap_waddr2", 32'(wb_q[m+2]), 32'd2);

        // enable dropped with a request in flight, then reset mid-request.
        lat = 10;
        wait_req("en_req_up");
        repeat (2) @(negedge clk);
        m = wa_q.size();
        enable = 1'b0;
        @(negedge clk);
        chk("en_drain_busy", 32'(busy), 32'd1);
        chk("en_drain_req", 32'(mem_req), 32'd1);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("en_idle_busy", 32'(busy), 32'd0);
        chk("en_idle_req", 32'(mem_req), 32'd0);
        chk("en_discarded", 32'(wa_q.size()), 32'(m));

        enable = 1'b1;
        pulse_frame(28'h0005000);
        wait_req("rst_req_up");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_req_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
